// File: rtl/paddle_axis_conditioner.sv
// Paddle/joystick axis conditioner for the Atari 800 core.
// Chooses between analog stick, PS/2 mouse and d-pad ramp. Positions are
// kept in a 9-bit signed accumulator and saturated to the signed 8-bit
// paddle range. Every output is registered.
module paddle_axis_conditioner #(
    parameter int STEP_CLAMP = 10,
    parameter int RAMP_DIV   = 28000,
    parameter int RAMP_STEP  = 2
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [24:0] ps2_mouse,
    input  logic [15:0] joya,
    input  logic [9:0]  joy,
    input  logic        cpu_halt,
    output logic [7:0]  ax_out,
    output logic [7:0]  ay_out,
    output logic [9:0]  j_out,
    output logic [1:0]  src
);

    localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic signed [8:0] STEP_MAX = 9'(STEP_CLAMP);
    localparam logic signed [9:0] RSTEP    = 10'(RAMP_STEP);

    typedef enum logic [1:0] {
        ANALOG  = 2'd0,
        MOUSE   = 2'd1,
        DIGITAL = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic signed [8:0]      acc_x, acc_y, acc_x_nxt, acc_y_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   old_stb, dir_prev;
    logic                   pkt, dpress, ramp_tick;
    logic signed [8:0]      dx_c, dy_c;
    logic signed [9:0]      cur_x, cur_y, base_x, base_y;
    logic signed [9:0]      step_x, step_y, ramp_x, ramp_y;
    logic [9:0]             j_sel;
    logic                   unused_bits;

    // Limit one mouse delta to +/-STEP_CLAMP.
    function automatic logic signed [8:0] clamp_step(input logic signed [8:0] d);
        if (d > STEP_MAX)
            return STEP_MAX;
        else if (d < -STEP_MAX)
            return -STEP_MAX;
        else
            return d;
    endfunction

    // Saturate a 10-bit signed sum into the signed 8-bit paddle range.
    function automatic logic signed [8:0] sat8(input logic signed [9:0] s);
        if (s > 10'sd127)
            return 9'sd127;
        else if (s < -10'sd128)
            return -9'sd128;
        else
            return s[8:0];
    endfunction

    assign unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3:2]};

    assign pkt       = (ps2_mouse[24] != old_stb);
    assign dpress    = (|joy[3:0]) && !dir_prev;
    assign ramp_tick = (cnt == CNT_W'(RAMP_DIV - 1));

    assign dx_c   = clamp_step({ps2_mouse[4], ps2_mouse[15:8]});
    assign dy_c   = clamp_step({ps2_mouse[5], ps2_mouse[23:16]});
    assign step_x = {dx_c[8], dx_c};
    assign step_y = {dy_c[8], dy_c};

    assign cur_x  = {acc_x[8], acc_x};
    assign cur_y  = {acc_y[8], acc_y};
    // Leaving ANALOG, the mouse position restarts from the centre.
    assign base_x = (state == ANALOG) ? 10'sd0 : cur_x;
    assign base_y = (state == ANALOG) ? 10'sd0 : cur_y;

    // Opposing directions held together give a zero step.
    assign ramp_x = (joy[0] && !joy[1]) ? RSTEP : (joy[1] && !joy[0]) ? -RSTEP : 10'sd0;
    assign ramp_y = (joy[2] && !joy[3]) ? RSTEP : (joy[3] && !joy[2]) ? -RSTEP : 10'sd0;

    assign j_sel = (state == MOUSE) ? {joy[9], ps2_mouse[1:0], joy[6:0]} : joy;

    // Source arbitration and accumulator/ramp next-state.
    always_comb begin
        state_nxt = state;
        acc_x_nxt = acc_x;
        acc_y_nxt = acc_y;
        cnt_nxt   = cnt;
        if ((joya != '0) || cpu_halt) begin
            state_nxt = ANALOG;
            acc_x_nxt = '0;
            acc_y_nxt = '0;
            cnt_nxt   = '0;
        end else if (pkt) begin
            state_nxt = MOUSE;
            acc_x_nxt = sat8(base_x + step_x);
            acc_y_nxt = sat8(base_y + step_y);
            cnt_nxt   = '0;
        end else if (dpress && (state != DIGITAL)) begin
            state_nxt = DIGITAL;
            cnt_nxt   = '0;
        end else if (state == DIGITAL) begin
            if (ramp_tick) begin
                cnt_nxt   = '0;
                acc_x_nxt = sat8(cur_x + ramp_x);
                acc_y_nxt = sat8(cur_y + ramp_y);
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    // State, accumulator and ramp counter registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= ANALOG;
            acc_x <= '0;
            acc_y <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            acc_x <= acc_x_nxt;
            acc_y <= acc_y_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Input history; also loaded in reset so a stale toggle or held d-pad is not an event.
    always_ff @(posedge clk_sys) begin
        old_stb  <= ps2_mouse[24];
        dir_prev <= |joy[3:0];
    end

    // Registered outputs to the core.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ax_out <= '0;
            ay_out <= '0;
            j_out  <= '0;
            src    <= '0;
        end else begin
            ax_out <= (state == ANALOG) ? joya[7:0]  : acc_x[7:0];
            ay_out <= (state == ANALOG) ? joya[15:8] : acc_y[7:0];
            j_out  <= j_sel;
            src    <= state;
        end
    end

endmodule

// File: tb/tb_paddle_axis_conditioner.sv
// Bench for paddle_axis_conditioner: a cycle model pushes the expected
// registered outputs per clock, a monitor pops and compares them, and each
// scenario task adds its own checks of hand-derived values.
module tb_paddle_axis_conditioner;

    localparam int SC = 10;
    localparam int RD = 4;
    localparam int RS = 2;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic [24:0] ps2_mouse = '0;
    logic [15:0] joya = '0;
    logic [9:0]  joy = '0;
    logic        cpu_halt = 1'b0;
    logic [7:0]  ax_out, ay_out;
    logic [9:0]  j_out;
    logic [1:0]  src;

    typedef struct packed {
        logic [7:0] ax;
        logic [7:0] ay;
        logic [9:0] j;
        logic [1:0] src;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_fail = 0;

    int   m_state = 0, m_ax = 0, m_ay = 0, m_cnt = 0;
    logic m_old = 1'b0, m_dirp = 1'b0;

    paddle_axis_conditioner #(.STEP_CLAMP(SC), .RAMP_DIV(RD), .RAMP_STEP(RS)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ps2_mouse(ps2_mouse),
        .joya     (joya),
        .joy      (joy),
        .cpu_halt (cpu_halt),
        .ax_out   (ax_out),
        .ay_out   (ay_out),
        .j_out    (j_out),
        .src      (src)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic int sat(int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic int clampd(int d);
        if (d > SC) return SC;
        if (d < -SC) return -SC;
        return d;
    endfunction

    // Push the outputs expected after the coming edge, advance the model, cross one edge.
    task automatic tick();
        exp_t e;
        int dx, dy, rx, ry;
        bit pkt, dpress;
        if (reset) begin
            e = '0;
        end else begin
            e.src = 2'(m_state);
            e.ax  = (m_state == 0) ? joya[7:0]  : 8'(m_ax);
            e.ay  = (m_state == 0) ? joya[15:8] : 8'(m_ay);
            e.j   = joy;
            if (m_state == 1) e.j[8:7] = ps2_mouse[1:0];
        end
        exp_q.push_back(e);
        if (reset) begin
            m_state = 0; m_ax = 0; m_ay = 0; m_cnt = 0;
        end else begin
            pkt    = (ps2_mouse[24] != m_old);
            dpress = (joy[3:0] != 4'b0) && !m_dirp;
            if (joya != 16'h0 || cpu_halt) begin
                m_state = 0; m_ax = 0; m_ay = 0; m_cnt = 0;
            end else if (pkt) begin
                dx = int'(ps2_mouse[15:8]);
                if (ps2_mouse[4]) dx -= 256;
                dy = int'(ps2_mouse[23:16]);
                if (ps2_mouse[5]) dy -= 256;
                if (m_state == 0) begin m_ax = 0; m_ay = 0; end
                m_ax = sat(m_ax + clampd(dx));
                m_ay = sat(m_ay + clampd(dy));
                m_state = 1; m_cnt = 0;
            end else if (dpress && m_state != 2) begin
                m_state = 2; m_cnt = 0;
            end else if (m_state == 2) begin
                if (m_cnt == RD - 1) begin
                    m_cnt = 0;
                    rx = 0; ry = 0;
                    if (joy[0]) rx += RS;
                    if (joy[1]) rx -= RS;
                    if (joy[2]) ry += RS;
                    if (joy[3]) ry -= RS;
                    m_ax = sat(m_ax + rx);
                    m_ay = sat(m_ay + ry);
                end else begin
                    m_cnt++;
                end
            end
        end
        m_old  = ps2_mouse[24];
        m_dirp = (joy[3:0] != 4'b0);
        @(negedge clk_sys);
    endtask

    task automatic set_pkt(input logic [8:0] dx, input logic [8:0] dy, input logic [1:0] btn);
        ps2_mouse = {~ps2_mouse[24], dy[7:0], dx[7:0], 2'b00, dy[8], dx[8], 2'b00, btn};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Scoreboard compare side: one popped expectation per clock edge.
    always @(posedge clk_sys) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_chk++;
            if ({ax_out, ay_out, j_out, src} !== mon_e) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t: got ax=%h ay=%h j=%h src=%0d, want ax=%h ay=%h j=%h src=%0d",
                         $time, ax_out, ay_out, j_out, src, mon_e.ax, mon_e.ay, mon_e.j, mon_e.src);
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        ps2_mouse[24] = 1'b1;
        tick(); tick(); tick();
        n_chk++;
        if ({ax_out, ay_out, j_out, src} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_values: ax=%h ay=%h j=%h src=%0d, want all zero", ax_out, ay_out, j_out, src);
        end
        reset = 1'b0;
        tick(); tick();
        n_chk++;
        if (src !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_stale_toggle: src=%0d, want 0", src);
        end
    endtask

    task automatic test_mouse();
        set_pkt(9'd5, 9'd0, 2'b00);
        tick(); tick();
        n_chk++;
        if (src !== 2'd1 || ax_out !== 8'd5) begin
            n_fail++;
            $display("FAIL mouse_first: src=%0d ax=%h, want src=1 ax=05", src, ax_out);
        end
        set_pkt(9'd50, 9'd0, 2'b00);
        tick(); tick();
        n_chk++;
        if (ax_out !== 8'd15) begin
            n_fail++;
            $display("FAIL mouse_clamp: ax=%h, want 0f", ax_out);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_pkt(9'h1F6, 9'd3, 2'b00);
            tick();
        end
        tick();
        n_chk++;
        if (ax_out !== 8'h80 || ay_out !== 8'h3C) begin
            n_fail++;
            $display("FAIL mouse_saturate: ax=%h ay=%h, want ax=80 ay=3c", ax_out, ay_out);
        end
        set_pkt(9'h1F6, 9'd0, 2'b00);
        tick(); tick();
        n_chk++;
        if (ax_out !== 8'h80) begin
            n_fail++;
            $display("FAIL mouse_saturate_hold: ax=%h, want 80", ax_out);
        end
    endtask

    task automatic test_analog_override();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_pkt(9'd10, 9'd0, 2'b00);
            tick();
        end
        tick();
        n_chk++;
        if (ax_out !== 8'd40) begin
            n_fail++;
            $display("FAIL analog_setup: ax=%h, want 28", ax_out);
        end
        joya = 16'h0030;
        tick(); tick();
        n_chk++;
        if (src !== 2'd0 || ax_out !== 8'h30) begin
            n_fail++;
            $display("FAIL analog_override: src=%0d ax=%h, want src=0 ax=30", src, ax_out);
        end
        joya = 16'h0000;
        tick(); tick();
        n_chk++;
        if (src !== 2'd0 || ax_out !== 8'h00) begin
            n_fail++;
            $display("FAIL analog_release: src=%0d ax=%h, want src=0 ax=00", src, ax_out);
        end
        set_pkt(9'd1, 9'd0, 2'b00);
        tick(); tick();
        n_chk++;
        if (ax_out !== 8'd1) begin
            n_fail++;
            $display("FAIL analog_acc_cleared: ax=%h, want 01", ax_out);
        end
    endtask

    task automatic test_ramp();
        do_reset();
        joy = 10'h001;
        for (int i = 0; i < 41; i++) tick();
        joy = 10'h003;
        for (int i = 0; i < 20; i++) tick();
        n_chk++;
        if (src !== 2'd2 || ax_out !== 8'd20) begin
            n_fail++;
            $display("FAIL ramp_cancel: src=%0d ax=%h, want src=2 ax=14", src, ax_out);
        end
        joy = 10'h001;
        for (int i = 0; i < 300; i++) tick();
        n_chk++;
        if (ax_out !== 8'h7F) begin
            n_fail++;
            $display("FAIL ramp_saturate: ax=%h, want 7f", ax_out);
        end
        joy = 10'h004;
        for (int i = 0; i < 20; i++) tick();
        joy = 10'h008;
        for (int i = 0; i < 30; i++) tick();
        joy = 10'h002;
        for (int i = 0; i < 20; i++) tick();
        joy = 10'h000;
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_buttons();
        do_reset();
        joy = 10'h100;
        set_pkt(9'd0, 9'd0, 2'b01);
        tick(); tick();
        n_chk++;
        if (src !== 2'd1 || j_out[8:7] !== 2'b01) begin
            n_fail++;
            $display("FAIL mouse_buttons: src=%0d j[8:7]=%b, want src=1 j[8:7]=01", src, j_out[8:7]);
        end
        cpu_halt = 1'b1;
        tick(); tick();
        n_chk++;
        if (src !== 2'd0 || j_out[8:7] !== 2'b10) begin
            n_fail++;
            $display("FAIL halt_buttons: src=%0d j[8:7]=%b, want src=0 j[8:7]=10", src, j_out[8:7]);
        end
        cpu_halt = 1'b0;
        joy = 10'h000;
        tick();
    endtask

    task automatic test_same_cycle();
        do_reset();
        set_pkt(9'd3, 9'd0, 2'b00);
        joy = 10'h001;
        tick(); tick();
        n_chk++;
        if (src !== 2'd1 || ax_out !== 8'd3) begin
            n_fail++;
            $display("FAIL pkt_vs_dpad: src=%0d ax=%h, want src=1 ax=03", src, ax_out);
        end
        joy = 10'h000;
        tick();
        joya = 16'h0505;
        set_pkt(9'd7, 9'd0, 2'b00);
        tick(); tick();
        n_chk++;
        if (src !== 2'd0 || ax_out !== 8'h05 || ay_out !== 8'h05) begin
            n_fail++;
            $display("FAIL pkt_vs_analog: src=%0d ax=%h ay=%h, want src=0 ax=05 ay=05", src, ax_out, ay_out);
        end
        joya = 16'h0000;
        tick(); tick();
        n_chk++;
        if (ax_out !== 8'h00) begin
            n_fail++;
            $display("FAIL pkt_vs_analog_acc: ax=%h, want 00", ax_out);
        end
    endtask

    task automatic test_reset_midway();
        do_reset();
        joy = 10'h001;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        set_pkt(9'd9, 9'd0, 2'b00);
        tick();
        n_chk++;
        if ({ax_out, ay_out, j_out, src} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_midway: ax=%h ay=%h j=%h src=%0d, want all zero", ax_out, ay_out, j_out, src);
        end
        reset = 1'b0;
        tick(); tick();
        n_chk++;
        if (src !== 2'd0 || ax_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_midway_after: src=%0d ax=%h, want src=0 ax=00", src, ax_out);
        end
        joy = 10'h000;
        tick();
    endtask

    initial begin
        @(negedge clk_sys);
        test_reset();
        test_mouse();
        test_saturate();
        test_analog_override();
        test_ramp();
        test_buttons();
        test_same_cycle();
        test_reset_midway();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/paddle_axis_conditioner.md
Name: paddle_axis_conditioner

Overview:
- Conditions pointing-device input into the analog paddle/joystick axes and the port-1 button word consumed by the Atari 800 core (JOY1X, JOY1Y, JOY1).
- Sits between hps_io (ps2_mouse, joystick_analog_0, joystick_0) and atari800top.
- Arbitrates between three sources: analog stick, PS/2 mouse (relative deltas accumulated into an absolute position), and digital d-pad (timed ramp).
- Saturates every position to the signed 8-bit paddle range.

Parameters:
- STEP_CLAMP, 10: maximum magnitude of one mouse delta applied per packet.
- RAMP_DIV, 28000: clk_sys cycles per d-pad ramp tick.
- RAMP_STEP, 2: position change per ramp tick.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ps2_mouse  in  25  [24] packet toggle strobe, [23:16] dy, [15:8] dx, [5] dy sign, [4] dx sign, [1:0] L/R buttons
- joya  in  16  analog stick: [7:0] X, [15:8] Y, signed
- joy  in  10  digital joystick: [0] right, [1] left, [2] down, [3] up, [9:4] buttons
- cpu_halt  in  1  core halted; forces the analog source
- ax_out  out  8  X axis to core, signed
- ay_out  out  8  Y axis to core, signed
- j_out  out  10  button/direction word to core
- src  out  2  active source: 0 ANALOG, 1 MOUSE, 2 DIGITAL

Behaviour:
- Reset: state ANALOG; acc_x = acc_y = 0; ramp counter 0; ax_out = ay_out = 0; j_out = 0; src = 0.
  - During reset, old_stb loads ps2_mouse[24], so a stale toggle is not seen as a packet.
- Packet detect: pkt = (ps2_mouse[24] != old_stb). old_stb updates every cycle.
- Mouse deltas:
  - dx = {ps2_mouse[4], ps2_mouse[15:8]}; dy = {ps2_mouse[5], ps2_mouse[23:16]}; both 9-bit signed.
  - Each delta is clamped to [-STEP_CLAMP, +STEP_CLAMP].
  - Sum formed in 10-bit signed with the 9-bit accumulator, then saturated to [-128, 127].
- Direction press edge: dpress = any of joy[3:0] set this cycle and previously all clear (registered history).
- Priority each cycle, highest first:
  1. (joya != 0) or cpu_halt: go ANALOG; acc_x, acc_y and ramp counter cleared.
  2. pkt: go MOUSE; apply the clamped delta to the accumulator in the same cycle. From ANALOG the accumulator starts at 0.
  3. dpress while not in DIGITAL: go DIGITAL; accumulator kept; ramp counter cleared.
- DIGITAL ramp:
  - Counter counts 0..RAMP_DIV-1; tick when it reaches RAMP_DIV-1, then wraps to 0.
  - On tick: right adds +RAMP_STEP to X, left adds -RAMP_STEP; down adds +RAMP_STEP to Y, up adds -RAMP_STEP.
  - Saturate to [-128, 127]. Opposing directions held together cancel (no change).
  - No direction held: position holds.
- MOUSE: accumulator changes only on pkt. The ramp counter is idle at 0.
- Outputs are registered with 1-cycle latency from the input/state update:
  - ax_out = ANALOG ? joya[7:0] : acc_x[7:0]; ay_out = ANALOG ? joya[15:8] : acc_y[7:0].
  - j_out = joy, except in MOUSE, where j_out[8:7] = ps2_mouse[1:0].
  - src = current state.
- Reset asserted mid-ramp or mid-packet: immediate return to reset values at the next edge. No partial update is applied.

Test Plan:
- Reset, then toggle ps2_mouse[24] with dx = +5 (sign 0) -> 2 cycles later src = 1, ax_out = 5; second packet dx = +50 -> ax_out = 15 (clamp 10).
- Send 20 packets of dx = -10 from 0 -> ax_out saturates at 0x80 (-128); one more packet leaves it at 0x80.
- In MOUSE with acc_x = 40, set joya = 16'h0030 -> src = 0, ax_out = 0x30; release joya to 0 -> ax_out = 0, acc_x cleared.
- Press joy[0] (RAMP_DIV = 4 in bench) -> src = 2, ax_out increases by 2 every 4 cycles until 127; press joy[0] and joy[1] together -> no change.
- Toggle ps2_mouse[24] with buttons = 2'b01 and joy[8:7] = 2'b10 -> j_out[8:7] = 2'b01; set cpu_halt = 1 -> src = 0, j_out[8:7] = 2'b10.
- Packet toggle and d-pad press in the same cycle -> src = 1 and the delta is applied; packet with joya != 0 in the same cycle -> src = 0 and the accumulator stays 0.
